// File: rtl/s7_display_arbiter.sv
// -----------------------------------------------------------------------------
// s7_display_arbiter
//
// Lets several BCD data sources share one multiplexed seven-segment display.
// A round-robin arbiter with a request/grant handshake hands the display to
// one source at a time. The owner keeps it for at least HOLD_CLK_COUNT clocks
// before a competing requester may take over. Every ownership change passes
// through a single blank cycle.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_req        per-source level-sensitive request
//   i_bcd_data   source r digits at [r*DISPLAYS_NUM*4 +: DISPLAYS_NUM*4]
//   o_gnt        registered one-hot grant (all zero when nobody owns)
//   o_bcd_data   registered digits for s7_display (BLANK_CODE when unowned)
//   o_busy       high while a source owns the display
//   o_owner_id   index of the current or most recent owner
// -----------------------------------------------------------------------------
module s7_display_arbiter #(
   parameter int         DISPLAYS_NUM   = 4,
   parameter int         REQ_NUM        = 2,
   parameter int         HOLD_CLK_COUNT = 40,
   parameter logic [3:0] BLANK_CODE     = 4'hF,
   localparam int        ID_W           = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
   localparam int        DATA_W         = DISPLAYS_NUM * 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [REQ_NUM-1:0]          i_req,
   input  logic [REQ_NUM*DATA_W-1:0]   i_bcd_data,
   output logic [REQ_NUM-1:0]          o_gnt,
   output logic [DATA_W-1:0]           o_bcd_data,
   output logic                        o_busy,
   output logic [ID_W-1:0]             o_owner_id
);

   localparam int                CNT_W     = (HOLD_CLK_COUNT > 1) ? $clog2(HOLD_CLK_COUNT) : 1;
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(HOLD_CLK_COUNT - 1);
   localparam logic [ID_W:0]     REQ_NUM_W = (ID_W + 1)'(REQ_NUM);
   localparam logic [DATA_W-1:0] BLANK_ALL = {DISPLAYS_NUM{BLANK_CODE}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_OWN,
      S_GAP
   } state_t;

   state_t              state_reg, state_next;
   logic [ID_W-1:0]     last_owner_reg, last_owner_next;
   logic [ID_W-1:0]     owner_id_reg, owner_id_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [REQ_NUM-1:0]  gnt_reg, gnt_next;
   logic [DATA_W-1:0]   bcd_reg, bcd_next;

   // Per-source digit slices, indexable by owner/winner id.
   logic [DATA_W-1:0]   src_data [REQ_NUM];

   // Round-robin candidates: cand_idx[k] is the source examined k-th,
   // starting at last_owner+1 and wrapping. The previous owner is examined
   // last, which gives it the lowest priority.
   logic [ID_W-1:0]     cand_idx [REQ_NUM];
   logic [REQ_NUM-1:0]  cand_req;
   logic [ID_W-1:0]     rr_winner;
   logic                rr_found;

   genvar gi;
   generate
      for (gi = 0; gi < REQ_NUM; gi++) begin : g_src
         logic [ID_W:0] rr_sum;

         assign src_data[gi] = i_bcd_data[gi*DATA_W +: DATA_W];
         assign rr_sum       = {1'b0, last_owner_reg} + (ID_W + 1)'(gi + 1);
         assign cand_idx[gi] = (rr_sum >= REQ_NUM_W) ? ID_W'(rr_sum - REQ_NUM_W)
                                                     : rr_sum[ID_W-1:0];
         assign cand_req[gi] = i_req[cand_idx[gi]];
      end
   endgenerate

   // Lowest candidate position wins: scanning downward lets the earliest
   // requesting candidate overwrite any later one.
   always_comb begin
      rr_found  = |cand_req;
      rr_winner = cand_idx[0];
      for (int k = REQ_NUM - 1; k >= 0; k--) begin
         if (cand_req[k]) begin
            rr_winner = cand_idx[k];
         end
      end
   end

   // gnt_reg is one-hot on the owner while in OWN, so it doubles as the
   // owner mask for the release and preempt checks.
   logic owner_req;
   logic others_req;

   assign owner_req  = |(i_req & gnt_reg);
   assign others_req = |(i_req & ~gnt_reg);

   always_comb begin
      state_next      = state_reg;
      last_owner_next = last_owner_reg;
      owner_id_next   = owner_id_reg;
      cnt_next        = cnt_reg;
      gnt_next        = gnt_reg;
      bcd_next        = bcd_reg;

      case (state_reg)
         S_OWN: begin
            if (!owner_req || ((cnt_reg == CNT_MAX) && others_req)) begin
               // Release takes precedence; either way the display blanks
               // for one cycle before anyone else is granted.
               state_next = S_GAP;
               gnt_next   = '0;
               bcd_next   = BLANK_ALL;
            end else begin
               bcd_next = src_data[owner_id_reg];
               if (cnt_reg != CNT_MAX) begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         default: begin  // S_IDLE and S_GAP arbitrate identically
            if (rr_found) begin
               state_next      = S_OWN;
               cnt_next        = '0;
               gnt_next        = REQ_NUM'(1) << rr_winner;
               owner_id_next   = rr_winner;
               last_owner_next = rr_winner;
               bcd_next        = src_data[rr_winner];
            end else begin
               state_next = S_IDLE;
               gnt_next   = '0;
               bcd_next   = BLANK_ALL;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg      <= S_IDLE;
         last_owner_reg <= ID_W'(REQ_NUM - 1);
         owner_id_reg   <= '0;
         cnt_reg        <= '0;
         gnt_reg        <= '0;
         bcd_reg        <= BLANK_ALL;
      end else begin
         state_reg      <= state_next;
         last_owner_reg <= last_owner_next;
         owner_id_reg   <= owner_id_next;
         cnt_reg        <= cnt_next;
         gnt_reg        <= gnt_next;
         bcd_reg        <= bcd_next;
      end
   end

   assign o_gnt      = gnt_reg;
   assign o_bcd_data = bcd_reg;
   assign o_busy     = (state_reg == S_OWN);
   assign o_owner_id = owner_id_reg;

endmodule

// File: tb/tb_s7_display_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for s7_display_arbiter: a 2-source and a 3-source instance, both
// with the default hold time. The reference model tracks only "who owns the
// display and for how many cycles". The blank handover cycle follows from
// the rule that a freed display is never re-granted on the same edge.
// -----------------------------------------------------------------------------
module tb_s7_display_arbiter;

   localparam int H = 40;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  req2;
   logic [31:0] data2;
   logic [1:0]  gnt2;
   logic [15:0] bcd2;
   logic        busy2;
   logic [0:0]  id2;
   logic [2:0]  req3;
   logic [47:0] data3;
   logic [2:0]  gnt3;
   logic [15:0] bcd3;
   logic        busy3;
   logic [1:0]  id3;

   int total = 0;
   int bad   = 0;

   s7_display_arbiter #(.DISPLAYS_NUM(4), .REQ_NUM(2), .HOLD_CLK_COUNT(H), .BLANK_CODE(4'hF)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_req(req2), .i_bcd_data(data2),
      .o_gnt(gnt2), .o_bcd_data(bcd2), .o_busy(busy2), .o_owner_id(id2));

   s7_display_arbiter #(.DISPLAYS_NUM(4), .REQ_NUM(3), .HOLD_CLK_COUNT(H), .BLANK_CODE(4'hF)) dut3 (
      .i_clk(clk), .i_rst(rst), .i_req(req3), .i_bcd_data(data3),
      .o_gnt(gnt3), .o_bcd_data(bcd3), .o_busy(busy3), .o_owner_id(id3));

   // ---------------- reference model (index 0: 2 sources, 1: 3 sources) ----
   int          m_owner [2];   // -1 when nobody owns the display
   int          m_held  [2];   // ownership cycles completed
   int          m_last  [2];
   int          m_id    [2];
   logic [15:0] m_bcd   [2];

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_owner[u] = -1;
         m_held[u]  = 0;
         m_last[u]  = (u == 0) ? 1 : 2;
         m_id[u]    = 0;
         m_bcd[u]   = 16'hFFFF;
      end
   endtask

   task automatic model_step(input int u);
      int          n;
      int          c;
      logic [2:0]  rq;
      logic [47:0] all;
      bit          others;
      bit          found;
      n   = (u == 0) ? 2 : 3;
      rq  = (u == 0) ? {1'b0, req2} : req3;
      all = (u == 0) ? {16'h0, data2} : data3;
      if (m_owner[u] >= 0) begin
         m_held[u]++;
         others = 0;
         for (int r = 0; r < n; r++) begin
            if (r != m_owner[u] && rq[r]) others = 1;
         end
         if (!rq[m_owner[u]] || (m_held[u] >= H && others)) m_owner[u] = -1;
         else m_bcd[u] = all[m_owner[u]*16 +: 16];
      end else begin
         found = 0;
         for (int k = 1; k <= n; k++) begin
            c = (m_last[u] + k) % n;
            if (!found && rq[c]) begin
               found      = 1;
               m_owner[u] = c;
               m_last[u]  = c;
               m_id[u]    = c;
               m_held[u]  = 0;
               m_bcd[u]   = all[c*16 +: 16];
            end
         end
      end
      if (m_owner[u] < 0) m_bcd[u] = 16'hFFFF;
   endtask

   function automatic logic [2:0] exp_gnt(input int u);
      return (m_owner[u] >= 0) ? 3'(1 << m_owner[u]) : 3'b000;
   endfunction

   // One clock: inputs are stable at the rising edge, outputs are then
   // observed at the following falling edge.
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         model_step(0);
         model_step(1);
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- tests ---------------------------------------------------
   task automatic test_reset();
      rst = 1'b1; req2 = '0; req3 = '0; data2 = 32'h2222_1111; data3 = '0;
      model_reset();
      #1;
      total++;
      if (gnt2 !== 2'b00 || bcd2 !== 16'hFFFF || busy2 !== 1'b0 || id2 !== 1'b0) begin
         bad++;
         $display("FAIL reset_async gnt=%b bcd=%h busy=%b id=%0d required 00/ffff/0/0", gnt2, bcd2, busy2, id2);
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      for (int t = 0; t < 20; t++) begin
         tick();
         total++;
         if (gnt2 !== 2'b00 || bcd2 !== 16'hFFFF || busy2 !== 1'b0 || id2 !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset t=%0d gnt=%b bcd=%h busy=%b id=%0d required 00/ffff/0/0", t, gnt2, bcd2, busy2, id2);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_data_follow();
      data2 = 32'h2222_1234; req2 = 2'b01;
      for (int t = 1; t <= 4; t++) begin
         if (t == 4) data2[15:0] = 16'h5678;
         tick();
         total++;
         if (gnt2 !== 2'b01 || busy2 !== 1'b1 || bcd2 !== ((t == 4) ? 16'h5678 : 16'h1234)) begin
            bad++;
            $display("FAIL data_follow t=%0d gnt=%b busy=%b bcd=%h required 01/1/%h", t, gnt2, busy2, bcd2, (t == 4) ? 16'h5678 : 16'h1234);
         end
      end
      req2 = 2'b00;
      for (int t = 0; t < 2; t++) begin
         tick();
         total++;
         if (gnt2 !== 2'b00 || busy2 !== 1'b0 || bcd2 !== 16'hFFFF || id2 !== 1'b0) begin
            bad++;
            $display("FAIL data_release t=%0d gnt=%b busy=%b bcd=%h id=%0d required 00/0/ffff/0", t, gnt2, busy2, bcd2, id2);
         end
      end
      $display("test_data_follow done");
   endtask

   task automatic test_rr_preempt();
      logic [1:0]  eg;
      logic [15:0] eb;
      do_reset();
      data2 = 32'h2222_1111; req2 = 2'b11;
      for (int t = 1; t <= 83; t++) begin
         tick();
         eg = (t <= 40) ? 2'b01 : (t == 41) ? 2'b00 : (t <= 81) ? 2'b10 : (t == 82) ? 2'b00 : 2'b01;
         eb = (eg == 2'b01) ? 16'h1111 : (eg == 2'b10) ? 16'h2222 : 16'hFFFF;
         total++;
         if (gnt2 !== eg || bcd2 !== eb || busy2 !== (eg != 2'b00)) begin
            bad++;
            $display("FAIL rr_preempt t=%0d gnt=%b bcd=%h busy=%b required %b/%h", t, gnt2, bcd2, busy2, eg, eb);
         end
      end
      $display("test_rr_preempt done");
   endtask

   task automatic test_async_reset();
      // Continues from test_rr_preempt: source 0 granted at its cycle 83.
      for (int t = 0; t < 50; t++) tick();
      total++;
      if (gnt2 !== 2'b10 || id2 !== 1'b1) begin
         bad++;
         $display("FAIL async_pre gnt=%b id=%0d required 10/1", gnt2, id2);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (gnt2 !== 2'b00 || busy2 !== 1'b0 || bcd2 !== 16'hFFFF || id2 !== 1'b0) begin
         bad++;
         $display("FAIL async_clear gnt=%b busy=%b bcd=%h id=%0d required 00/0/ffff/0", gnt2, busy2, bcd2, id2);
      end
      model_reset();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      tick();
      total++;
      if (gnt2 !== 2'b01 || bcd2 !== 16'h1111 || id2 !== 1'b0) begin
         bad++;
         $display("FAIL async_first_grant gnt=%b bcd=%h id=%0d required 01/1111/0", gnt2, bcd2, id2);
      end
      $display("test_async_reset done");
   endtask

   task automatic test_release();
      do_reset();
      data2 = 32'h2222_ABCD; req2 = 2'b01;
      for (int t = 1; t <= 10; t++) begin
         tick();
         total++;
         if (gnt2 !== 2'b01 || bcd2 !== 16'hABCD) begin
            bad++;
            $display("FAIL release_own t=%0d gnt=%b bcd=%h required 01/abcd", t, gnt2, bcd2);
         end
      end
      req2 = 2'b00;
      for (int t = 0; t < 2; t++) begin
         tick();
         total++;
         if (gnt2 !== 2'b00 || busy2 !== 1'b0 || bcd2 !== 16'hFFFF || id2 !== 1'b0) begin
            bad++;
            $display("FAIL release_blank t=%0d gnt=%b busy=%b bcd=%h id=%0d required 00/0/ffff/0", t, gnt2, busy2, bcd2, id2);
         end
      end
      $display("test_release done");
   endtask

   task automatic test_lone_owner();
      do_reset();
      data2 = 32'h2222_1111; req2 = 2'b10;
      for (int t = 0; t < 100; t++) begin
         tick();
         total++;
         if (gnt2 !== 2'b10 || id2 !== 1'b1) begin
            bad++;
            $display("FAIL lone_owner t=%0d gnt=%b id=%0d required 10/1", t, gnt2, id2);
         end
      end
      req2 = 2'b00;
      tick();
      req2 = 2'b11;   // previous owner re-requests during the blank cycle
      tick();
      total++;
      if (gnt2 !== 2'b01 || bcd2 !== 16'h1111) begin
         bad++;
         $display("FAIL reassert_low_prio gnt=%b bcd=%h required 01/1111", gnt2, bcd2);
      end
      req2 = 2'b00;
      tick(); tick();
      $display("test_lone_owner done");
   endtask

   task automatic test_wrap3();
      logic [2:0]  eg;
      logic [15:0] eb;
      do_reset();
      data3 = {16'h3333, 16'h2222, 16'h1111}; req3 = 3'b100;
      for (int t = 1; t <= 5; t++) begin
         tick();
         total++;
         if (gnt3 !== 3'b100 || bcd3 !== 16'h3333 || id3 !== 2'd2) begin
            bad++;
            $display("FAIL wrap_own2 t=%0d gnt=%b bcd=%h id=%0d required 100/3333/2", t, gnt3, bcd3, id3);
         end
      end
      req3 = 3'b011;   // release and new requests in the same cycle
      for (int t = 1; t <= 42; t++) begin
         tick();
         eg = (t == 1) ? 3'b000 : (t <= 41) ? 3'b001 : 3'b000;
         if (t == 42) eg = 3'b000;
         eb = (eg == 3'b001) ? 16'h1111 : 16'hFFFF;
         total++;
         if (gnt3 !== eg || bcd3 !== eb) begin
            bad++;
            $display("FAIL wrap_seq t=%0d gnt=%b bcd=%h required %b/%h", t, gnt3, bcd3, eg, eb);
         end
      end
      tick();
      total++;
      if (gnt3 !== 3'b010 || bcd3 !== 16'h2222 || id3 !== 2'd1) begin
         bad++;
         $display("FAIL wrap_next gnt=%b bcd=%h id=%0d required 010/2222/1", gnt3, bcd3, id3);
      end
      req3 = 3'b000;
      tick(); tick();
      $display("test_wrap3 done");
   endtask

   task automatic test_random();
      do_reset();
      for (int t = 0; t < 1500; t++) begin
         for (int b = 0; b < 2; b++) if ($urandom_range(0, 24) == 0) req2[b] = ~req2[b];
         for (int b = 0; b < 3; b++) if ($urandom_range(0, 24) == 0) req3[b] = ~req3[b];
         if ($urandom_range(0, 3) == 0) data2 = $urandom;
         if ($urandom_range(0, 3) == 0) data3 = {16'($urandom), 32'($urandom)};
         tick();
         total++;
         if ({1'b0, gnt2} !== exp_gnt(0) || bcd2 !== m_bcd[0] || busy2 !== (m_owner[0] >= 0)
             || 32'(id2) !== 32'(m_id[0]) || !$onehot0(gnt2)) begin
            bad++;
            $display("FAIL random2 t=%0d gnt=%b bcd=%h busy=%b id=%0d required %b/%h/%0d/%0d",
                     t, gnt2, bcd2, busy2, id2, exp_gnt(0), m_bcd[0], m_owner[0] >= 0, m_id[0]);
         end
         total++;
         if (gnt3 !== exp_gnt(1) || bcd3 !== m_bcd[1] || busy3 !== (m_owner[1] >= 0)
             || 32'(id3) !== 32'(m_id[1]) || !$onehot0(gnt3)) begin
            bad++;
            $display("FAIL random3 t=%0d gnt=%b bcd=%h busy=%b id=%0d required %b/%h/%0d/%0d",
                     t, gnt3, bcd3, busy3, id3, exp_gnt(1), m_bcd[1], m_owner[1] >= 0, m_id[1]);
         end
      end
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_data_follow();
      test_rr_preempt();
      test_async_reset();
      test_release();
      test_lone_owner();
      test_wrap3();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/s7_display_arbiter.md
# s7_display_arbiter

Shares one multiplexed seven-segment display between several BCD data sources. Runs a round-robin arbiter with a request/grant handshake and a minimum ownership time. Drives the `i_bcd_data` input of `s7_display` with the current owner's digits, or with a blank code while no one owns the display. Sits between the application sources and `s7_display`, in the same clock domain.

## Interface
Parameters:
- `DISPLAYS_NUM`, 4: digits per source; each digit is a 4-bit BCD nibble.
- `REQ_NUM`, 2: number of requesters; must be ≥ 2.
- `HOLD_CLK_COUNT`, 40: minimum ownership in clocks before another requester may preempt the owner; must be ≥ 1. The default equals one full refresh frame of `s7_display` (10 × 4).
- `BLANK_CODE`, 4'hF: nibble driven on every digit while no one owns the display.

Ports (clock and reset first):
- `i_clk`, input, 1: system clock; all state changes on its rising edge.
- `i_rst`, input, 1: reset, asynchronous, active-high.
- `i_req`, input, REQ_NUM: request per source; level-sensitive.
- `i_bcd_data`, input, REQ_NUM*DISPLAYS_NUM*4: source r's digits occupy bits `[r*DISPLAYS_NUM*4 +: DISPLAYS_NUM*4]`.
- `o_gnt`, output, REQ_NUM: one-hot grant, or all zero; registered.
- `o_bcd_data`, output, DISPLAYS_NUM*4: data to `s7_display`; registered.
- `o_busy`, output, 1: high while in state OWN.
- `o_owner_id`, output, max(1,$clog2(REQ_NUM)): index of the current or most recent owner.

## Operation
States:
- IDLE: no owner.
- OWN: one source holds the display.
- GAP: one-cycle handover with no owner.

Arbitration:
- Round-robin search starts at `last_owner+1` and wraps from REQ_NUM-1 to 0; the first source with `i_req` high wins.
- `last_owner` resets to REQ_NUM-1, so source 0 has top priority after reset.

Hold counter:
- Cleared on the edge that enters OWN.
- Increments on each OWN cycle and saturates at HOLD_CLK_COUNT-1.
- Width is $clog2(HOLD_CLK_COUNT), minimum 1.

Transitions (evaluated at each rising edge):
- IDLE → OWN when any `i_req` is high. The winner is granted: `o_gnt[w]`=1, `o_owner_id`=w, `last_owner`=w, `o_bcd_data` loaded with w's slice.
- OWN → GAP when the owner's `i_req` is low (release, at any counter value).
- OWN → GAP when the counter equals HOLD_CLK_COUNT-1 and any other `i_req` is high (preempt).
- OWN → OWN otherwise. Grant is held, and `o_bcd_data` reloads from the owner's slice every cycle.
- GAP → OWN when any `i_req` is high, using round-robin arbitration.
- GAP → IDLE when no `i_req` is high.

Outputs in IDLE and GAP:
- `o_gnt`=0, `o_busy`=0, every nibble of `o_bcd_data` = BLANK_CODE.
- `o_owner_id` holds its last value.

Handshake and data rules:
- A source must keep `i_req` high for as long as it wants the display.
- Grant drops on the edge after the release is sampled.
- Data outside the owner's slice is ignored.
- BCD nibbles pass through unmodified; no validity check.

Boundary conditions:
- Owner release and another request in the same cycle: release wins → GAP, then the other source is granted.
- A lone owner with no competitors keeps the display indefinitely; the saturated counter does not cause a switch.
- An owner whose request was withdrawn and re-asserted during GAP is eligible, but has the lowest priority.
- Reset mid-operation: all state clears immediately, with no wait for a clock edge.

## Timing
Reset values:
- state = IDLE, `last_owner` = REQ_NUM-1, counter = 0.
- `o_gnt` = 0, `o_busy` = 0, `o_owner_id` = 0.
- `o_bcd_data` = all nibbles BLANK_CODE.

Latencies:
- `i_req` high before edge N (state IDLE) → `o_gnt` and `o_busy` high, and data valid, after edge N.
- Owner data change before edge N → visible on `o_bcd_data` after edge N (one-cycle latency).
- Preempt: the owner holds exactly HOLD_CLK_COUNT cycles, then GAP for 1 cycle, then the new grant.
- Handover therefore costs exactly one blank cycle; `o_gnt` is never high for two sources at once.
- `i_rst` deassertion: the first grant can occur on the first rising edge after `i_rst` falls.

## Test plan
1. Assert reset, then release it, with `i_req`=0 for 20 clocks → `o_gnt`=0, `o_busy`=0, `o_bcd_data`=16'hFFFF, `o_owner_id`=0 throughout.
2. Set `req[0]`=1 with data 16'h1234; after 3 cycles change the data to 16'h5678 → `o_gnt`=2'b01 one edge after the request; `o_bcd_data`=1234, then 5678 one edge after the change.
3. Assert `req`=2'b11 together (source 0 data 16'h1111, source 1 data 16'h2222) → source 0 owns for exactly 40 cycles, 1 GAP cycle at FFFF, source 1 owns for 40 cycles, then source 0 again.
4. Source 0 owns; drop `req[0]` on ownership cycle 10 with no other requests → GAP, then IDLE, `o_bcd_data`=FFFF, `o_busy`=0, `o_owner_id` stays 0.
5. Assert `i_rst` asynchronously mid-OWN of source 1 while `req`=2'b11 → outputs clear before the next edge; after release, source 0 is granted first.
6. With REQ_NUM=3, source 2 owns and releases while `req`=3'b011 → wrap-around grants source 0, then source 1 after 40 cycles and a 1-cycle GAP.
